// File: rtl/exception_wb_ctrl_pkg.sv
// rtl/exception_wb_ctrl_pkg.sv - shared exception codes, status register index and stage entry type
// Purpose: constants shared by the execute-side code generator and the writeback controller.
// Contents: EXC_* codes, STATUS_REG index, stage_t pipeline entry {valid, we, exc, rd, data}.
package exception_wb_ctrl_pkg;

    localparam logic [2:0] EXC_NONE = 3'd0;
    localparam logic [2:0] EXC_ADD  = 3'd1;
    localparam logic [2:0] EXC_ADDI = 3'd2;
    localparam logic [2:0] EXC_SUB  = 3'd3;

    localparam int STATUS_REG = 30;
    localparam int STAGE_W    = 42;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [2:0]  exc;
        logic [4:0]  rd;
        logic [31:0] data;
    } stage_t;

endpackage

// File: rtl/exc_stage_reg.sv
// rtl/exc_stage_reg.sv - 42-bit pipeline stage latch with hold and bubble insertion
// Purpose: one pipeline latch carrying an instruction and its exception code.
// Ports:
//   clock  in   system clock
//   reset  in   synchronous active-high clear (entry becomes invalid, all fields 0)
//   hold   in   keep current contents (has priority over bubble)
//   bubble in   load an empty entry instead of d
//   d      in   stage_t entry from the previous stage
//   q      out  stage_t entry held by this stage
module exc_stage_reg
    import exception_wb_ctrl_pkg::*;
(
    input  logic   clock,
    input  logic   reset,
    input  logic   hold,
    input  logic   bubble,
    input  stage_t d,
    output stage_t q
);

    stage_t q_q;
    stage_t q_d;

    always_comb begin
        q_d = q_q;
        if (!hold) begin
            q_d = bubble ? stage_t'('0) : d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= stage_t'('0);
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/exception_wb_ctrl.sv
// rtl/exception_wb_ctrl.sv - exception code carriage through X/M, M/W and writeback to status register
// Purpose: carries the execute exception code with its instruction, turns an excepting
//   instruction's writeback into a write of the code into STATUS_REG, and keeps sticky
//   last-code/pending status with ack plus a saturating exception counter.
// Ports:
//   clock, reset                  system clock, synchronous active-high reset
//   x_valid/x_exception/x_rd/x_result/x_we   instruction leaving execute
//   stall                         freeze M and W, flush ignored, nothing retires
//   flush                         replace the X instruction with a bubble in M
//   w_we/w_rd/w_data              register file write port (combinational from W)
//   exc_pending/exc_code/exc_ack  sticky status and host acknowledge
//   exc_count                     saturating count of retired exceptions
module exception_wb_ctrl
    import exception_wb_ctrl_pkg::*;
#(
    parameter int STATUS_REG = exception_wb_ctrl_pkg::STATUS_REG,
    parameter int CNT_W      = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             x_valid,
    input  logic [2:0]       x_exception,
    input  logic [4:0]       x_rd,
    input  logic [31:0]      x_result,
    input  logic             x_we,
    input  logic             stall,
    input  logic             flush,
    output logic             w_we,
    output logic [4:0]       w_rd,
    output logic [31:0]      w_data,
    output logic             exc_pending,
    output logic [2:0]       exc_code,
    input  logic             exc_ack,
    output logic [CNT_W-1:0] exc_count
);

    stage_t x_entry;
    stage_t m_q;
    stage_t w_q;

    assign x_entry = '{valid: x_valid, we: x_we, exc: x_exception, rd: x_rd, data: x_result};

    exc_stage_reg u_xm (
        .clock  (clock),
        .reset  (reset),
        .hold   (stall),
        .bubble (flush),
        .d      (x_entry),
        .q      (m_q)
    );

    exc_stage_reg u_mw (
        .clock  (clock),
        .reset  (reset),
        .hold   (stall),
        .bubble (1'b0),
        .d      (m_q),
        .q      (w_q)
    );

    logic w_exc;
    logic retire_exc;

    assign w_exc      = w_q.valid && (w_q.exc != EXC_NONE);
    // Status is updated only on the edge where W actually moves on, so a stalled
    // excepting instruction is counted once.
    assign retire_exc = w_exc && !stall;

    always_comb begin
        w_we   = 1'b0;
        w_rd   = w_q.rd;
        w_data = w_q.data;
        if (w_exc) begin
            w_we   = 1'b1;
            w_rd   = 5'(STATUS_REG);
            w_data = {29'b0, w_q.exc};
        end else begin
            w_we = w_q.valid && w_q.we && (w_q.rd != 5'd0);
        end
    end

    logic             exc_pending_q, exc_pending_d;
    logic [2:0]       exc_code_q, exc_code_d;
    logic [CNT_W-1:0] exc_count_q, exc_count_d;

    always_comb begin
        exc_pending_d = exc_pending_q;
        exc_code_d    = exc_code_q;
        exc_count_d   = exc_count_q;
        // A newly retiring exception beats a coincident ack.
        if (retire_exc) begin
            exc_pending_d = 1'b1;
            exc_code_d    = w_q.exc;
            if (exc_count_q != {CNT_W{1'b1}}) begin
                exc_count_d = exc_count_q + CNT_W'(1);
            end
        end else if (exc_ack && exc_pending_q) begin
            exc_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            exc_pending_q <= 1'b0;
            exc_code_q    <= 3'd0;
            exc_count_q   <= '0;
        end else begin
            exc_pending_q <= exc_pending_d;
            exc_code_q    <= exc_code_d;
            exc_count_q   <= exc_count_d;
        end
    end

    assign exc_pending = exc_pending_q;
    assign exc_code    = exc_code_q;
    assign exc_count   = exc_count_q;

endmodule

// File: tb/tb_exception_wb_ctrl.sv
// tb/tb_exception_wb_ctrl.sv - self-checking bench for exception_wb_ctrl with queue reference model
module tb_exception_wb_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        x_valid = 1'b0;
    logic [2:0]  x_exception = 3'd0;
    logic [4:0]  x_rd = 5'd0;
    logic [31:0] x_result = 32'd0;
    logic        x_we = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        exc_ack = 1'b0;

    logic        w_we, s_w_we;
    logic [4:0]  w_rd, s_w_rd;
    logic [31:0] w_data, s_w_data;
    logic        exc_pending, s_exc_pending;
    logic [2:0]  exc_code, s_exc_code;
    logic [7:0]  exc_count;
    logic [1:0]  s_exc_count;

    always #5 clock = ~clock;

    exception_wb_ctrl #(.STATUS_REG(30), .CNT_W(8)) u_dut (
        .clock(clock), .reset(reset), .x_valid(x_valid), .x_exception(x_exception),
        .x_rd(x_rd), .x_result(x_result), .x_we(x_we), .stall(stall), .flush(flush),
        .w_we(w_we), .w_rd(w_rd), .w_data(w_data), .exc_pending(exc_pending),
        .exc_code(exc_code), .exc_ack(exc_ack), .exc_count(exc_count)
    );

    exception_wb_ctrl #(.STATUS_REG(30), .CNT_W(2)) u_sat (
        .clock(clock), .reset(reset), .x_valid(x_valid), .x_exception(x_exception),
        .x_rd(x_rd), .x_result(x_result), .x_we(x_we), .stall(stall), .flush(flush),
        .w_we(s_w_we), .w_rd(s_w_rd), .w_data(s_w_data), .exc_pending(s_exc_pending),
        .exc_code(s_exc_code), .exc_ack(exc_ack), .exc_count(s_exc_count)
    );

    typedef struct {
        bit        v;
        bit        we;
        bit [2:0]  e;
        bit [4:0]  rd;
        bit [31:0] d;
    } ent_t;

    // pipe[0] is the instruction at writeback, pipe[1] the one behind it.
    ent_t pipe[$];
    int   m_pending, m_code, m_count, m_count2;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        ent_t z;
        z = '{v: 0, we: 0, e: 0, rd: 0, d: 0};
        pipe.delete();
        pipe.push_back(z);
        pipe.push_back(z);
        m_pending = 0;
        m_code    = 0;
        m_count   = 0;
        m_count2  = 0;
    endtask

    task automatic check_outputs(input string tag);
        ent_t w;
        w = pipe[0];
        if (w.v && w.e != 0) begin
            chk({tag, "_w_we"}, 32'(w_we), 32'd1);
            chk({tag, "_w_rd"}, 32'(w_rd), 32'd30);
            chk({tag, "_w_data"}, w_data, 32'(w.e));
        end else begin
            chk({tag, "_w_we"}, 32'(w_we), 32'(w.v && w.we && w.rd != 0));
            if (w.v) begin
                chk({tag, "_w_rd"}, 32'(w_rd), 32'(w.rd));
                chk({tag, "_w_data"}, w_data, w.d);
            end
        end
        chk({tag, "_pending"}, 32'(exc_pending), 32'(m_pending));
        chk({tag, "_code"}, 32'(exc_code), 32'(m_code));
        chk({tag, "_count"}, 32'(exc_count), 32'(m_count));
        chk({tag, "_sat_count"}, 32'(s_exc_count), 32'(m_count2));
        chk({tag, "_sat_pending"}, 32'(s_exc_pending), 32'(m_pending));
    endtask

    task automatic set_x(input bit v, input bit [2:0] e, input bit [4:0] rd,
                         input bit [31:0] d, input bit we);
        x_valid = v;
        x_exception = e;
        x_rd = rd;
        x_result = d;
        x_we = we;
    endtask

    task automatic bubble();
        set_x(0, 0, 0, 0, 0);
    endtask

    // Check current outputs, then advance one clock and the model with it.
    task automatic step(input string tag, input bit st, input bit fl, input bit ak);
        ent_t w, nx;
        stall = st;
        flush = fl;
        exc_ack = ak;
        #1;
        check_outputs(tag);
        w = pipe[0];
        if (!st && w.v && w.e != 0) begin
            m_pending = 1;
            m_code = w.e;
            if (m_count < 255) m_count++;
            if (m_count2 < 3) m_count2++;
        end else if (ak && m_pending != 0) begin
            m_pending = 0;
        end
        if (!st) begin
            nx.v  = x_valid && !fl;
            nx.we = x_we && !fl;
            nx.e  = fl ? 3'd0 : x_exception;
            nx.rd = x_rd;
            nx.d  = x_result;
            pipe.delete(0);
            pipe.push_back(nx);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        stall = 1'b1;
        flush = 1'b1;
        exc_ack = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        exc_ack = 1'b0;
        model_clear();
        chk({tag, "_rst_w_we"}, 32'(w_we), 32'd0);
        chk({tag, "_rst_w_rd"}, 32'(w_rd), 32'd0);
        chk({tag, "_rst_w_data"}, w_data, 32'd0);
        chk({tag, "_rst_pending"}, 32'(exc_pending), 32'd0);
        chk({tag, "_rst_code"}, 32'(exc_code), 32'd0);
        chk({tag, "_rst_count"}, 32'(exc_count), 32'd0);
        chk({tag, "_rst_sat_count"}, 32'(s_exc_count), 32'd0);
    endtask

    initial begin
        @(posedge clock);
        #1;
        do_reset("init");

        // 1: plain write, no exception
        set_x(1, 0, 5, 32'hDEAD, 1);
        step("t1a", 0, 0, 0);
        bubble();
        step("t1b", 0, 0, 0);
        chk("t1_w_we", 32'(w_we), 32'd1);
        chk("t1_w_rd", 32'(w_rd), 32'd5);
        chk("t1_w_data", w_data, 32'hDEAD);
        step("t1c", 0, 0, 0);

        // write to r0 dropped
        set_x(1, 0, 0, 32'h1234, 1);
        step("r0a", 0, 0, 0);
        bubble();
        step("r0b", 0, 0, 0);
        step("r0c", 0, 0, 0);

        // 2: add overflow
        set_x(1, 1, 7, 32'h5555, 1);
        step("t2a", 0, 0, 0);
        bubble();
        step("t2b", 0, 0, 0);
        chk("t2_w_rd", 32'(w_rd), 32'd30);
        step("t2c", 0, 0, 0);
        chk("t2_count", 32'(exc_count), 32'd1);
        step("t2d", 0, 0, 0);

        // 3: back-to-back addi, sub
        set_x(1, 2, 8, 32'h1, 1);
        step("t3a", 0, 0, 0);
        set_x(1, 3, 9, 32'h2, 1);
        step("t3b", 0, 0, 0);
        bubble();
        step("t3c", 0, 0, 0);
        step("t3d", 0, 0, 0);
        chk("t3_code", 32'(exc_code), 32'd3);
        chk("t3_count", 32'(exc_count), 32'd3);

        // 4: stall with sub in W, then flush of an add
        set_x(1, 3, 10, 32'h3, 1);
        step("t4a", 0, 0, 0);
        bubble();
        step("t4b", 0, 0, 0);
        step("t4s1", 1, 1, 0);
        step("t4s2", 1, 0, 0);
        step("t4s3", 1, 0, 0);
        step("t4go", 0, 0, 0);
        chk("t4_count", 32'(exc_count), 32'd4);
        set_x(1, 1, 11, 32'h4, 1);
        step("t4f", 0, 1, 0);
        bubble();
        step("t4g", 0, 0, 0);
        step("t4h", 0, 0, 0);

        // 5: ack cases; new exception coincides with ack first
        set_x(1, 2, 12, 32'h5, 1);
        step("t5a", 0, 0, 0);
        bubble();
        step("t5b", 0, 0, 0);
        step("t5c", 0, 0, 1);
        chk("t5_pend_kept", 32'(exc_pending), 32'd1);
        chk("t5_code2", 32'(exc_code), 32'd2);
        step("t5d", 0, 0, 1);
        chk("t5_pend_clr", 32'(exc_pending), 32'd0);
        step("t5e", 0, 0, 1);

        // 6: saturation with reserved codes, then reset mid-pipeline
        for (int i = 0; i < 5; i++) begin
            set_x(1, 3'(4 + (i % 4)), 5'(i + 1), 32'(i), 1);
            step("t6s", 0, 0, 0);
        end
        bubble();
        step("t6t", 0, 0, 0);
        step("t6u", 0, 0, 0);
        chk("t6_sat", 32'(s_exc_count), 32'd3);
        set_x(1, 1, 3, 32'h9, 1);
        step("t6v", 0, 0, 0);
        set_x(1, 2, 4, 32'hA, 1);
        step("t6w", 0, 0, 0);
        bubble();
        do_reset("t6");
        step("t6x", 0, 0, 0);
        step("t6y", 0, 0, 0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset("rnd");
            end else begin
                set_x(1'($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                      5'($urandom), $urandom, 1'($urandom));
                step("rnd", 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0),
                     1'($urandom_range(0, 3) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
